// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   - fetch FSM state encoding
//   - opcode field bounds inside a 16-bit instruction word
//   - opcodes of the two-word (opcode + 16-bit immediate) instructions
//   - is_two_word(): opcode classifier used by the fetch FSM
package fetch_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 16;
   localparam int OPC_HI  = 15;
   localparam int OPC_LO  = 11;
   localparam int OPC_W   = OPC_HI - OPC_LO + 1;

   typedef enum logic [1:0] {
      RV_HI = 2'd0,
      RV_LO = 2'd1,
      OP    = 2'd2,
      IMM   = 2'd3
   } fetch_state_e;

   // Opcodes followed by a 16-bit immediate word
   localparam logic [OPC_W-1:0] OPC_LDM  = 5'h0C;
   localparam logic [OPC_W-1:0] OPC_IADD = 5'h0D;
   localparam logic [OPC_W-1:0] OPC_LDD  = 5'h0E;
   localparam logic [OPC_W-1:0] OPC_STD  = 5'h0F;
   localparam logic [OPC_W-1:0] OPC_JMPI = 5'h10;

   function automatic logic is_two_word(input logic [OPC_W-1:0] opc);
      logic two;
      case (opc)
         OPC_LDM, OPC_IADD, OPC_LDD, OPC_STD, OPC_JMPI: two = 1'b1;
         default:                                       two = 1'b0;
      endcase
      return two;
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
//   Owns the PC, loads the reset vector from memory words 0/1, assembles
//   one- and two-word instructions, and handles stall / redirect.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   memData               instruction word at memAddress (same cycle)
//   memAddress, memStall  instruction memory address / NOP-forcing stall
//   stallIn               hazard stall: freeze PC, state and IF/ID
//   branchTaken/Target    redirect request and new PC
//   ifid*                 IF/ID register: opcode word, immediate,
//                         return address, valid
//
// state | meaning
// RV_HI | reading reset-vector upper half from word 0
// RV_LO | reading reset-vector lower half from word 1, then jump to it
// OP    | fetching an opcode word
// IMM   | fetching the immediate word of a two-word instruction
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = fetch_pkg::ADDR_W,
   parameter int INSTR_W = fetch_pkg::INSTR_W,
   parameter int OPC_HI  = fetch_pkg::OPC_HI,
   parameter int OPC_LO  = fetch_pkg::OPC_LO
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] memData,
   output logic [ADDR_W-1:0]  memAddress,
   output logic               memStall,
   input  logic               stallIn,
   input  logic               branchTaken,
   input  logic [ADDR_W-1:0]  branchTarget,
   output logic [INSTR_W-1:0] ifidInstruction,
   output logic [INSTR_W-1:0] ifidImmediate,
   output logic [ADDR_W-1:0]  ifidPc,
   output logic               ifidValid
);

   fetch_state_e       r_state;
   fetch_state_e       w_state_nxt;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  w_pc_inc;
   logic [INSTR_W-1:0] r_vec_hi;
   logic [INSTR_W-1:0] r_op_hold;
   logic               w_two_word;

   assign w_pc_inc   = r_pc + 1'b1;   // wraps modulo 2^ADDR_W
   assign w_two_word = is_two_word(memData[OPC_HI:OPC_LO]);

   always_ff @(posedge clk) begin
      if (rst) r_state <= RV_HI;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RV_HI: w_state_nxt = RV_LO;
         RV_LO: w_state_nxt = OP;
         OP: begin
            if (branchTaken)   w_state_nxt = OP;
            else if (stallIn)  w_state_nxt = OP;
            else if (w_two_word) w_state_nxt = IMM;
            else               w_state_nxt = OP;
         end
         IMM: begin
            if (branchTaken)   w_state_nxt = OP;
            else if (stallIn)  w_state_nxt = IMM;
            else               w_state_nxt = OP;
         end
         default: w_state_nxt = RV_HI;
      endcase
   end

   always_comb begin
      memAddress = r_pc;
      memStall   = stallIn;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc            <= '0;
         r_vec_hi        <= '0;
         r_op_hold       <= '0;
         ifidInstruction <= '0;
         ifidImmediate   <= '0;
         ifidPc          <= '0;
         ifidValid       <= 1'b0;
      end else begin
         case (r_state)
            RV_HI: begin
               r_vec_hi <= memData;
               r_pc     <= ADDR_W'(1);
            end
            RV_LO: begin
               r_pc <= ADDR_W'({r_vec_hi, memData});
            end
            OP, IMM: begin
               if (branchTaken) begin
                  // any half-fetched opcode in r_op_hold is simply abandoned
                  r_pc      <= branchTarget;
                  ifidValid <= 1'b0;
               end else if (!stallIn) begin
                  r_pc <= w_pc_inc;
                  if (r_state == IMM) begin
                     ifidInstruction <= r_op_hold;
                     ifidImmediate   <= memData;
                     ifidPc          <= w_pc_inc;
                     ifidValid       <= 1'b1;
                  end else if (w_two_word) begin
                     r_op_hold <= memData;
                     ifidValid <= 1'b0;
                  end else begin
                     ifidInstruction <= memData;
                     ifidImmediate   <= '0;
                     ifidPc          <= w_pc_inc;
                     ifidValid       <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] memData;
   logic [31:0] memAddress;
   logic        memStall;
   logic        stallIn;
   logic        branchTaken;
   logic [31:0] branchTarget;
   logic [15:0] ifidInstruction;
   logic [15:0] ifidImmediate;
   logic [31:0] ifidPc;
   logic        ifidValid;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .memData         (memData),
      .memAddress      (memAddress),
      .memStall        (memStall),
      .stallIn         (stallIn),
      .branchTaken     (branchTaken),
      .branchTarget    (branchTarget),
      .ifidInstruction (ifidInstruction),
      .ifidImmediate   (ifidImmediate),
      .ifidPc          (ifidPc),
      .ifidValid       (ifidValid)
   );

   // Instruction memory image: reset vector 0x0040
   // 0x40 ADD, 0x41 NOP, 0x42 ADD, 0x43/44 LDM #BEEF, 0x45 ADD,
   // 0x46/47 IADD #1234, 0x100 ADD, 0xFFFFFFFF ADD
   function automatic logic [15:0] mem_rd(input logic [31:0] a);
      logic [15:0] d;
      case (a)
         32'h0000_0000: d = 16'h0000;
         32'h0000_0001: d = 16'h0040;
         32'h0000_0040: d = 16'h0800;
         32'h0000_0041: d = 16'h0000;
         32'h0000_0042: d = 16'h0801;
         32'h0000_0043: d = 16'h6123;
         32'h0000_0044: d = 16'hBEEF;
         32'h0000_0045: d = 16'h0802;
         32'h0000_0046: d = 16'h6805;
         32'h0000_0047: d = 16'h1234;
         32'h0000_0100: d = 16'h0803;
         32'hFFFF_FFFF: d = 16'h0804;
         default:       d = 16'h0000;
      endcase
      return d;
   endfunction

   assign memData = memStall ? 16'h0000 : mem_rd(memAddress);

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_ifid(input string tag, input logic [15:0] ins, input logic [15:0] imm,
                           input logic [31:0] pc, input logic v);
      chk({tag, ".ins"}, 32'(ifidInstruction), 32'(ins));
      chk({tag, ".imm"}, 32'(ifidImmediate),   32'(imm));
      chk({tag, ".pc"},  ifidPc,               pc);
      chk({tag, ".v"},   32'(ifidValid),       32'(v));
   endtask

   initial begin
      rst = 1'b1; stallIn = 1'b0; branchTaken = 1'b0; branchTarget = '0;
      step();
      step();
      chk("rst.addr", memAddress, 32'h0);
      chk_ifid("rst", 16'h0, 16'h0, 32'h0, 1'b0);
      rst = 1'b0;

      step(); chk("rv.addr1", memAddress, 32'h1);  chk("rv.v1", 32'(ifidValid), 0);
      step(); chk("rv.addr2", memAddress, 32'h40); chk("rv.v2", 32'(ifidValid), 0);

      step(); chk_ifid("w1", 16'h0800, 16'h0, 32'h41, 1'b1);
      step(); chk_ifid("w2", 16'h0000, 16'h0, 32'h42, 1'b1);
      step(); chk_ifid("w3", 16'h0801, 16'h0, 32'h43, 1'b1);
      chk("w3.addr", memAddress, 32'h43);

      step(); chk("ldm.bubble", 32'(ifidValid), 0); chk("ldm.addr", memAddress, 32'h44);
      step(); chk_ifid("ldm", 16'h6123, 16'hBEEF, 32'h45, 1'b1);

      stallIn = 1'b1;
      #1 chk("stl.memStall", 32'(memStall), 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stl%0d.addr", i), memAddress, 32'h45);
         chk_ifid($sformatf("stl%0d", i), 16'h6123, 16'hBEEF, 32'h45, 1'b1);
      end
      stallIn = 1'b0;
      #1 chk("stl.rel", 32'(memStall), 0);
      step(); chk_ifid("resume", 16'h0802, 16'h0, 32'h46, 1'b1);

      step(); chk("iadd.bubble", 32'(ifidValid), 0); chk("iadd.addr", memAddress, 32'h47);
      branchTaken = 1'b1; branchTarget = 32'h100; stallIn = 1'b1;
      step(); chk("br.addr", memAddress, 32'h100); chk("br.v", 32'(ifidValid), 0);
      branchTaken = 1'b0; stallIn = 1'b0;
      step(); chk_ifid("br.tgt", 16'h0803, 16'h0, 32'h101, 1'b1);

      branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFF;
      step(); chk("wrap.addr0", memAddress, 32'hFFFF_FFFF);
      branchTaken = 1'b0;
      step(); chk_ifid("wrap", 16'h0804, 16'h0, 32'h0, 1'b1);
      chk("wrap.addr1", memAddress, 32'h0);

      branchTaken = 1'b1; branchTarget = 32'h43;
      step(); chk("mr.addr", memAddress, 32'h43);
      branchTaken = 1'b0;
      step(); chk("mr.bubble", 32'(ifidValid), 0); chk("mr.imm_addr", memAddress, 32'h44);
      rst = 1'b1;
      step(); chk("mr.rst_addr", memAddress, 32'h0);
      chk_ifid("mr.rst", 16'h0, 16'h0, 32'h0, 1'b0);
      rst = 1'b0;
      step(); chk("mr.rv1", memAddress, 32'h1);
      step(); chk("mr.rv2", memAddress, 32'h40);
      step(); chk_ifid("mr.first", 16'h0800, 16'h0, 32'h41, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
